// File: rtl/div_seq_ctrl_if.sv
// Request/response handshake and divider-core hookup for div_seq_ctrl.
// slave: the controller itself. master: the system side, which issues requests,
// consumes results and hosts the iterative divider core.
interface div_seq_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        rsp_valid;
    logic [31:0] rsp_res;
    logic        rsp_ready;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_start;
    logic        div_busy;
    logic [31:0] div_q;
    logic [31:0] div_r;

    modport master (
        output req_valid, req_op, req_rs1, req_rs2, rsp_ready, div_busy, div_q, div_r,
        input  req_ready, rsp_valid, rsp_res, div_a, div_b, div_start
    );

    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, rsp_ready, div_busy, div_q, div_r,
        output req_ready, rsp_valid, rsp_res, div_a, div_b, div_start
    );
endinterface

// File: rtl/div_seq_ctrl.sv
// Sequencing controller wrapping an unsigned iterative divider core to implement
// RISC-V DIV/DIVU/REM/REMU. Signed ops are reduced to magnitudes and the sign is
// fixed up on the result. Divide-by-zero and signed overflow bypass the core.
// Optional feature: define DIV_RESULT_CACHE_EN to keep the last core result and
// answer a matching DIV/REM (same operands and signedness) without the core.
module div_seq_ctrl (
    input logic          clk,
    input logic          rst,
    div_seq_ctrl_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StStart, StWaitBusy, StRun, StDone} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q;
    logic [31:0] mag_a_q, mag_b_q;
    logic        q_neg_q, r_neg_q;
    logic [31:0] res_q;

    logic        accept;
    logic        is_signed;
    logic        neg_a, neg_b;
    logic        div_zero, overflow;
    logic        cache_hit;
    logic        skip_core;
    logic        core_done;
    logic [31:0] special_res;

    // Sign fix-up of an unsigned quotient/remainder; op[1] selects remainder, op[0] unsigned.
    function automatic logic [31:0] fix_result(input logic [1:0]  op,
                                               input logic [31:0] q,
                                               input logic [31:0] r,
                                               input logic        q_neg,
                                               input logic        r_neg);
        logic sgn;
        sgn = ~op[0];
        if (op[1]) begin
            return (sgn && r_neg) ? (32'd0 - r) : r;
        end
        return (sgn && q_neg) ? (32'd0 - q) : q;
    endfunction

    assign accept    = (state_q == StIdle) && bus.req_valid;
    assign is_signed = ~bus.req_op[0];
    assign neg_a     = bus.req_rs1[31];
    assign neg_b     = bus.req_rs2[31];
    assign div_zero  = (bus.req_rs2 == 32'd0);
    assign overflow  = is_signed && (bus.req_rs1 == 32'h8000_0000) &&
                       (bus.req_rs2 == 32'hFFFF_FFFF);
    assign core_done = (state_q == StRun) && !bus.div_busy;

`ifdef DIV_RESULT_CACHE_EN
    logic        cache_valid_q;
    logic [31:0] cache_a_q, cache_b_q;
    logic        cache_signed_q;
    logic [31:0] cache_q_q, cache_r_q;
    logic [31:0] raw_a_q, raw_b_q;

    assign cache_hit = cache_valid_q && (bus.req_rs1 == cache_a_q) &&
                       (bus.req_rs2 == cache_b_q) && (is_signed == cache_signed_q);

    // Remember the operands of the current op and the raw result of the last core run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_valid_q  <= 1'b0;
            cache_a_q      <= 32'd0;
            cache_b_q      <= 32'd0;
            cache_signed_q <= 1'b0;
            cache_q_q      <= 32'd0;
            cache_r_q      <= 32'd0;
            raw_a_q        <= 32'd0;
            raw_b_q        <= 32'd0;
        end else begin
            if (accept) begin
                raw_a_q <= bus.req_rs1;
                raw_b_q <= bus.req_rs2;
            end
            if (core_done) begin
                cache_valid_q  <= 1'b1;
                cache_a_q      <= raw_a_q;
                cache_b_q      <= raw_b_q;
                cache_signed_q <= ~op_q[0];
                cache_q_q      <= bus.div_q;
                cache_r_q      <= bus.div_r;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    assign skip_core = div_zero || overflow || cache_hit;

    // Result for requests that never reach the core.
    always_comb begin
        special_res = 32'd0;
        if (div_zero) begin
            special_res = bus.req_op[1] ? bus.req_rs1 : 32'hFFFF_FFFF;
        end else if (overflow) begin
            special_res = bus.req_op[1] ? 32'd0 : 32'h8000_0000;
        end
`ifdef DIV_RESULT_CACHE_EN
        else begin
            special_res = fix_result(bus.req_op, cache_q_q, cache_r_q, neg_a ^ neg_b, neg_a);
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (bus.req_valid) state_d = skip_core ? StDone : StStart;
            StStart:    state_d = StWaitBusy;
            StWaitBusy: if (bus.div_busy) state_d = StRun;
            StRun:      if (!bus.div_busy) state_d = StDone;
            StDone:     if (bus.rsp_ready) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Outputs; the core operands come straight from the held magnitude registers.
    always_comb begin
        bus.req_ready = (state_q == StIdle);
        bus.rsp_valid = (state_q == StDone);
        bus.div_start = (state_q == StStart);
        bus.rsp_res   = res_q;
        bus.div_a     = mag_a_q;
        bus.div_b     = mag_b_q;
    end

    // Operand capture on acceptance and result capture on bypass or core completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= 2'd0;
            mag_a_q <= 32'd0;
            mag_b_q <= 32'd0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            res_q   <= 32'd0;
        end else begin
            if (accept) begin
                op_q    <= bus.req_op;
                mag_a_q <= (is_signed && neg_a) ? (32'd0 - bus.req_rs1) : bus.req_rs1;
                mag_b_q <= (is_signed && neg_b) ? (32'd0 - bus.req_rs2) : bus.req_rs2;
                q_neg_q <= neg_a ^ neg_b;
                r_neg_q <= neg_a;
                if (skip_core) begin
                    res_q <= special_res;
                end
            end
            if (core_done) begin
                res_q <= fix_result(op_q, bus.div_q, bus.div_r, q_neg_q, r_neg_q);
            end
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: a 33-cycle-busy divider core model, a cycle-level
// reference model of the controller's observable behaviour, directed cases with
// literal expectations and randomized transactions.
module tb_div_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_starts = 0;

    div_seq_ctrl_if bus ();

    div_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Divider core: busy for 33 cycles after a start, reads operands at the end.
    int          core_cnt;
    logic [31:0] core_q, core_r;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_cnt <= 0;
            core_q   <= 32'd0;
            core_r   <= 32'd0;
        end else if (core_cnt == 0 && bus.div_start) begin
            core_cnt <= 33;
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                core_q <= (bus.div_b != 0) ? bus.div_a / bus.div_b : 32'hFFFF_FFFF;
                core_r <= (bus.div_b != 0) ? bus.div_a % bus.div_b : bus.div_a;
            end
        end
    end
    assign bus.div_busy = (core_cnt != 0);
    assign bus.div_q    = core_q;
    assign bus.div_r    = core_r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            2'd0:    return 32'(sa / sb);
            2'd1:    return a / b;
            2'd2:    return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    function automatic logic [31:0] mag(input logic sgn, input logic [31:0] x);
        return (sgn && x[31]) ? (32'd0 - x) : x;
    endfunction

    // Reference model state.
    bit          m_idle = 1'b1;
    int          m_done_at = -1;
    int          m_start_at = -1;
    logic [31:0] m_res, m_mag_a, m_mag_b;
    bit          mc_valid = 1'b0, mp_valid = 1'b0;
    logic [31:0] mc_a, mc_b, mp_a, mp_b;
    bit          mc_s, mp_s;

    // Compare process: checks every cycle, then advances the model.
    always @(negedge clk) begin
        bit exp_valid, sgn, special, hit;
        if (rst) begin
            chk("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
            chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
            chk("reset_div_start", {31'd0, bus.div_start}, 32'd0);
            chk("reset_rsp_res", bus.rsp_res, 32'd0);
            chk("reset_div_a", bus.div_a, 32'd0);
            chk("reset_div_b", bus.div_b, 32'd0);
            m_idle = 1'b1; m_done_at = -1; m_start_at = -1;
            mc_valid = 1'b0; mp_valid = 1'b0;
        end else begin
            exp_valid = !m_idle && cyc >= m_done_at;
            if (bus.div_start) n_starts++;
            chk("req_ready", {31'd0, bus.req_ready}, {31'd0, m_idle});
            chk("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, exp_valid});
            chk("div_start", {31'd0, bus.div_start}, {31'd0, (cyc == m_start_at)});
            if (exp_valid) chk("rsp_res", bus.rsp_res, m_res);
            if (!m_idle && m_start_at >= 0 && cyc >= m_start_at && cyc < m_done_at) begin
                chk("div_a_hold", bus.div_a, m_mag_a);
                chk("div_b_hold", bus.div_b, m_mag_b);
            end
            if (exp_valid && mp_valid) begin
                mc_valid = 1'b1; mc_a = mp_a; mc_b = mp_b; mc_s = mp_s; mp_valid = 1'b0;
            end
            if (m_idle && bus.req_valid) begin
                sgn     = !bus.req_op[0];
                special = (bus.req_rs2 == 0) ||
                          (sgn && bus.req_rs1 == 32'h8000_0000 && bus.req_rs2 == 32'hFFFF_FFFF);
`ifdef DIV_RESULT_CACHE_EN
                hit = mc_valid && mc_a == bus.req_rs1 && mc_b == bus.req_rs2 && mc_s == sgn;
`else
                hit = 1'b0;
`endif
                m_idle  = 1'b0;
                m_res   = ref_res(bus.req_op, bus.req_rs1, bus.req_rs2);
                m_mag_a = mag(sgn, bus.req_rs1);
                m_mag_b = mag(sgn, bus.req_rs2);
                if (special || hit) begin
                    m_done_at = cyc + 1; m_start_at = -1;
                end else begin
                    m_done_at = cyc + 36; m_start_at = cyc + 1;
                    mp_valid = 1'b1; mp_a = bus.req_rs1; mp_b = bus.req_rs2; mp_s = sgn;
                end
            end else if (exp_valid && bus.rsp_ready) begin
                m_idle = 1'b1; m_start_at = -1;
            end
        end
    end

    task automatic finish_fatal(input string why);
        $display("FAIL %s: timed out (cycle %0d)", why, cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    endtask

    // Present a request and return the cycle in which it was accepted.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int acc);
        int n;
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_rs1 = a; bus.req_rs2 = b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_ready && n < 200);
        if (!bus.req_ready) finish_fatal("accept");
        acc = cyc;
    endtask

    // Wait for the response with junk requests on the bus, hold, then consume it.
    task automatic await_rsp(input int hold, output int lat, output logic [31:0] res);
        int n, acc;
        acc = cyc;
        n = 0;
        do begin
            @(posedge clk); #1;
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.req_op = 2'($urandom); bus.req_rs1 = $urandom; bus.req_rs2 = $urandom;
            @(negedge clk);
            n++;
        end while (!bus.rsp_valid && n < 100);
        if (!bus.rsp_valid) finish_fatal("response");
        lat = cyc - acc;
        res = bus.rsp_res;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic directed(input string name, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_res,
                            input int exp_lat, input int hold);
        int acc, lat, s0;
        logic [31:0] res;
        issue(op, a, b, acc);
        s0 = n_starts;
        await_rsp(hold, lat, res);
        chk({name, "_res"}, res, exp_res);
        chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({name, "_starts"}, 32'(n_starts - s0), (exp_lat == 36) ? 32'd1 : 32'd0);
    endtask

    initial begin
        #1000000;
        finish_fatal("watchdog");
    end

    initial begin
        int          acc, lat, hit_lat;
        logic [31:0] res, a, b, pa, pb;
        logic [1:0]  op;
`ifdef DIV_RESULT_CACHE_EN
        hit_lat = 1;
`else
        hit_lat = 36;
`endif
        bus.req_valid = 1'b0; bus.req_op = 2'd0; bus.req_rs1 = 32'd0; bus.req_rs2 = 32'd0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        directed("divu_100_7", 2'd1, 32'd100, 32'd7, 32'd14, 36, 0);
        directed("divu_50_3", 2'd1, 32'd50, 32'd3, 32'd16, 36, 0);
        directed("remu_100_7", 2'd3, 32'd100, 32'd7, 32'd2, 36, 1);
        directed("div_m7_2", 2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 36, 0);
        directed("rem_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, hit_lat, 0);
        directed("div_7_m2", 2'd0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 36, 2);
        directed("div_5_0", 2'd0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        directed("remu_5_0", 2'd3, 32'd5, 32'd0, 32'd5, 1, 0);
        directed("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        directed("hold_divu_9_2", 2'd1, 32'd9, 32'd2, 32'd4, 36, 10);
        directed("div_100_7", 2'd0, 32'd100, 32'd7, 32'd14, 36, 0);
        directed("rem_100_7", 2'd2, 32'd100, 32'd7, 32'd2, hit_lat, 0);

        // Reset in the middle of a core run abandons it.
        issue(2'd1, 32'd1000, 32'd9, acc);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        while (cyc < acc + 20) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        directed("divu_9_3", 2'd1, 32'd9, 32'd3, 32'd3, 36, 0);

        pa = 32'd100; pb = 32'd7;
        for (int t = 0; t < 120; t++) begin
            op = 2'($urandom);
            case ($urandom_range(0, 9))
                0: begin a = $urandom; b = 32'd0; end
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2, 3: begin a = pa; b = pb; end
                4, 5: begin
                    a = $urandom_range(0, 200); b = $urandom_range(1, 20);
                    if ($urandom_range(0, 1) == 1) a = 32'd0 - a;
                    if ($urandom_range(0, 1) == 1) b = 32'd0 - b;
                end
                default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
            endcase
            pa = a; pb = b;
            issue(op, a, b, acc);
            await_rsp($urandom_range(0, 3), lat, res);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
